// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding and the {pc, instr} queue entry layout.
package ifetch_pkg;

    localparam int IF_ADDR_W  = 16;
    localparam int IF_INSTR_W = 16;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bundle of memory, redirect and decode-side signals of the fetch controller.
// The master modport is the controller's view; slave is the environment's view.
interface ifetch_ctrl_if #(
    parameter int QUEUE_DEPTH = 2
);
    import ifetch_pkg::*;

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic                  enable;
    logic [IF_ADDR_W-1:0]  imem_addr;
    logic [IF_INSTR_W-1:0] imem_data;
    logic                  redirect_valid;
    logic [IF_ADDR_W-1:0]  redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [IF_INSTR_W-1:0] out_instr;
    logic [IF_ADDR_W-1:0]  out_pc;
    logic [CW-1:0]         queue_count;
    logic                  halted;

    modport master (
        input  enable, imem_data, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, queue_count, halted
    );

    modport slave (
        output enable, imem_data, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, queue_count, halted
    );

endinterface

// File: rtl/ifetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with flush and occupancy count.
// Flush wins over push/pop; the head reads as zero while the queue is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  entry_t        i_data,
    output entry_t        o_head,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC register, fetch FSM and push/pop control.
// Defining IFETCH_HALT_DETECT_EN stops fetching after a word with opcode 4'hF.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [IF_ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                   QUEUE_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    ifetch_ctrl_if.master bus
);

    localparam int            CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    state_t               r_state;
    logic [IF_ADDR_W-1:0] r_pc;
    logic                 r_halted;

    entry_t        w_head;
    logic          w_valid;
    logic [CW-1:0] w_count;
    logic          w_popEn;
    logic          w_pushEn;
    logic          w_haltHit;

    // A redirect squashes both the pop and the push of its cycle.
    assign w_popEn  = w_valid && bus.out_ready && !bus.redirect_valid;
    assign w_pushEn = (r_state == FETCH) && bus.enable && !bus.redirect_valid &&
                      ((w_count < DEPTH_C) || w_popEn);

`ifdef IFETCH_HALT_DETECT_EN
    assign w_haltHit = w_pushEn && (bus.imem_data[15:12] == HALT_OPCODE);
`else
    assign w_haltHit = 1'b0;
`endif

    // On a halt word the PC is not advanced, so it keeps pointing at the halt address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc     <= bus.redirect_pc;
            r_halted <= 1'b0;
            if (r_state == HALT) begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_haltHit) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_pushEn) begin
                        r_pc <= r_pc + 16'd1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ifetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_pushEn),
        .i_pop  (w_popEn),
        .i_flush(bus.redirect_valid),
        .i_data ('{pc: r_pc, instr: bus.imem_data}),
        .o_head (w_head),
        .o_valid(w_valid),
        .o_count(w_count)
    );

    assign bus.imem_addr   = r_pc;
    assign bus.out_valid   = w_valid;
    assign bus.out_instr   = w_head.instr;
    assign bus.out_pc      = w_head.pc;
    assign bus.queue_count = w_count;
    assign bus.halted      = r_halted;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl with a combinational instruction memory model.
// Halt checks follow IFETCH_HALT_DETECT_EN so the bench suits either build.
module tb_ifetch_ctrl;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    ifetch_ctrl_if #(.QUEUE_DEPTH(2)) bus ();

    ifetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory: fixed words at 0..3 and 5, otherwise {A, addr[11:0]}.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        case (a)
            16'h0000: memWord = 16'h1111;
            16'h0001: memWord = 16'h2222;
            16'h0002: memWord = 16'h3333;
            16'h0003: memWord = 16'h4444;
            16'h0005: memWord = 16'hF000;
            default:  memWord = {4'hA, a[11:0]};
        endcase
    endfunction

    assign bus.imem_data = memWord(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n              = 1'b0;
        bus.enable         = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.enable         = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        #2;
        assertCount++; if (bus.imem_addr !== RESET_PC) begin failCount++; $display("[TB] FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid); end
        assertCount++; if (bus.out_instr !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_instr got=%h exp=0000", bus.out_instr); end
        assertCount++; if (bus.out_pc !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_pc got=%h exp=0000", bus.out_pc); end
        assertCount++; if (bus.queue_count !== 2'd0) begin failCount++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.queue_count); end
        assertCount++; if (bus.halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted got=%b exp=0", bus.halted); end
    endtask

    task automatic test_stream();
        logic [15:0] expW [4];
        expW = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL stream_idle_valid got=%b exp=0", bus.out_valid); end
        assertCount++; if (bus.imem_addr !== 16'h0000) begin failCount++; $display("[TB] FAIL stream_addr0 got=%h exp=0000", bus.imem_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            assertCount++; if (bus.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL stream_valid k=%0d got=%b exp=1", k, bus.out_valid); end
            assertCount++; if (bus.out_pc !== 16'(k)) begin failCount++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, bus.out_pc, 16'(k)); end
            assertCount++; if (bus.out_instr !== expW[k]) begin failCount++; $display("[TB] FAIL stream_instr k=%0d got=%h exp=%h", k, bus.out_instr, expW[k]); end
            assertCount++; if (bus.queue_count !== 2'd1) begin failCount++; $display("[TB] FAIL stream_count k=%0d got=%0d exp=1", k, bus.queue_count); end
            assertCount++; if (bus.imem_addr !== 16'(k + 1)) begin failCount++; $display("[TB] FAIL stream_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 16'(k + 1)); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] expW [4];
        expW = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            assertCount++; if (bus.queue_count !== 2'd2) begin failCount++; $display("[TB] FAIL bp_count k=%0d got=%0d exp=2", k, bus.queue_count); end
            assertCount++; if (bus.imem_addr !== 16'h0002) begin failCount++; $display("[TB] FAIL bp_addr k=%0d got=%h exp=0002", k, bus.imem_addr); end
            assertCount++; if (bus.out_instr !== 16'h1111 || bus.out_pc !== 16'h0000) begin failCount++; $display("[TB] FAIL bp_hold k=%0d got=%h/%h exp=0000/1111", k, bus.out_pc, bus.out_instr); end
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            assertCount++; if (bus.out_pc !== 16'(k) || bus.out_instr !== expW[k]) begin failCount++; $display("[TB] FAIL bp_drain k=%0d got=%h/%h exp=%h/%h", k, bus.out_pc, bus.out_instr, 16'(k), expW[k]); end
            assertCount++; if (bus.queue_count !== 2'd2) begin failCount++; $display("[TB] FAIL bp_drain_count k=%0d got=%0d exp=2", k, bus.queue_count); end
            assertCount++; if (bus.imem_addr !== 16'(k + 2)) begin failCount++; $display("[TB] FAIL bp_drain_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 16'(k + 2)); end
        end
    endtask

    task automatic test_redirect();
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        step();
        bus.redirect_valid = 1'b0;
        assertCount++; if (bus.queue_count !== 2'd0) begin failCount++; $display("[TB] FAIL redir_count got=%0d exp=0", bus.queue_count); end
        assertCount++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0000) begin failCount++; $display("[TB] FAIL redir_flush got=%b/%h exp=0/0000", bus.out_valid, bus.out_instr); end
        assertCount++; if (bus.imem_addr !== 16'h0040) begin failCount++; $display("[TB] FAIL redir_addr got=%h exp=0040", bus.imem_addr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0040 || bus.out_instr !== 16'hA040) begin failCount++; $display("[TB] FAIL redir_first got=%h/%h exp=0040/A040", bus.out_pc, bus.out_instr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0041 || bus.out_instr !== 16'hA041) begin failCount++; $display("[TB] FAIL redir_second got=%h/%h exp=0041/A041", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_idle_redirect();
        resetDut();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0010;
        step();
        bus.redirect_valid = 1'b0;
        assertCount++; if (bus.imem_addr !== 16'h0010) begin failCount++; $display("[TB] FAIL idle_redir_addr got=%h exp=0010", bus.imem_addr); end
        step();
        assertCount++; if (bus.imem_addr !== 16'h0010 || bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_hold got=%h/%b exp=0010/0", bus.imem_addr, bus.out_valid); end
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_to_fetch_valid got=%b exp=0", bus.out_valid); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0010 || bus.out_instr !== 16'hA010) begin failCount++; $display("[TB] FAIL idle_first got=%h/%h exp=0010/A010", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_pause();
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b0;
        step();
        step();
        bus.enable = 1'b0;
        step();
        step();
        assertCount++; if (bus.queue_count !== 2'd1 || bus.imem_addr !== 16'h0001) begin failCount++; $display("[TB] FAIL pause_hold got=%0d/%h exp=1/0001", bus.queue_count, bus.imem_addr); end
        assertCount++; if (bus.out_instr !== 16'h1111) begin failCount++; $display("[TB] FAIL pause_instr got=%h exp=1111", bus.out_instr); end
        bus.out_ready = 1'b1;
        step();
        assertCount++; if (bus.out_valid !== 1'b0 || bus.queue_count !== 2'd0) begin failCount++; $display("[TB] FAIL pause_drain got=%b/%0d exp=0/0", bus.out_valid, bus.queue_count); end
        assertCount++; if (bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000) begin failCount++; $display("[TB] FAIL pause_zero got=%h/%h exp=0000/0000", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_wrap();
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFF;
        step();
        bus.redirect_valid = 1'b0;
        assertCount++; if (bus.imem_addr !== 16'hFFFF) begin failCount++; $display("[TB] FAIL wrap_start got=%h exp=FFFF", bus.imem_addr); end
        step();
        assertCount++; if (bus.imem_addr !== 16'h0000) begin failCount++; $display("[TB] FAIL wrap_addr got=%h exp=0000", bus.imem_addr); end
        assertCount++; if (bus.out_pc !== 16'hFFFF || bus.out_instr !== 16'hAFFF) begin failCount++; $display("[TB] FAIL wrap_out1 got=%h/%h exp=FFFF/AFFF", bus.out_pc, bus.out_instr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h1111) begin failCount++; $display("[TB] FAIL wrap_out2 got=%h/%h exp=0000/1111", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_halt();
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0004;
        step();
        bus.redirect_valid = 1'b0;
        step();
        assertCount++; if (bus.out_pc !== 16'h0004 || bus.out_instr !== 16'hA004) begin failCount++; $display("[TB] FAIL halt_pre got=%h/%h exp=0004/A004", bus.out_pc, bus.out_instr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0005 || bus.out_instr !== 16'hF000) begin failCount++; $display("[TB] FAIL halt_word got=%h/%h exp=0005/F000", bus.out_pc, bus.out_instr); end
`ifdef IFETCH_HALT_DETECT_EN
        assertCount++; if (bus.halted !== 1'b1 || bus.imem_addr !== 16'h0005) begin failCount++; $display("[TB] FAIL halt_enter got=%b/%h exp=1/0005", bus.halted, bus.imem_addr); end
        step();
        assertCount++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 16'h0005 || bus.halted !== 1'b1) begin failCount++; $display("[TB] FAIL halt_stay got=%b/%h/%b exp=0/0005/1", bus.out_valid, bus.imem_addr, bus.halted); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0000;
        step();
        bus.redirect_valid = 1'b0;
        assertCount++; if (bus.halted !== 1'b0 || bus.imem_addr !== 16'h0000) begin failCount++; $display("[TB] FAIL halt_leave got=%b/%h exp=0/0000", bus.halted, bus.imem_addr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h1111) begin failCount++; $display("[TB] FAIL halt_resume got=%h/%h exp=0000/1111", bus.out_pc, bus.out_instr); end
`else
        assertCount++; if (bus.halted !== 1'b0 || bus.imem_addr !== 16'h0006) begin failCount++; $display("[TB] FAIL nohalt_run got=%b/%h exp=0/0006", bus.halted, bus.imem_addr); end
        step();
        assertCount++; if (bus.out_pc !== 16'h0006 || bus.out_instr !== 16'hA006 || bus.halted !== 1'b0) begin failCount++; $display("[TB] FAIL nohalt_next got=%h/%h/%b exp=0006/A006/0", bus.out_pc, bus.out_instr, bus.halted); end
`endif
    endtask

    task automatic test_async_reset();
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        assertCount++; if (bus.out_valid !== 1'b0 || bus.queue_count !== 2'd0) begin failCount++; $display("[TB] FAIL arst_queue got=%b/%0d exp=0/0", bus.out_valid, bus.queue_count); end
        assertCount++; if (bus.imem_addr !== RESET_PC || bus.out_instr !== 16'h0000) begin failCount++; $display("[TB] FAIL arst_addr got=%h/%h exp=%h/0000", bus.imem_addr, bus.out_instr, RESET_PC); end
        resetDut();
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        assertCount++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h1111 || bus.queue_count !== 2'd1) begin failCount++; $display("[TB] FAIL arst_restart got=%h/%h/%0d exp=0000/1111/1", bus.out_pc, bus.out_instr, bus.queue_count); end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_idle_redirect();
        test_pause();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction fetch controller between the 16-bit-address, 16-bit-word asynchronous-read instruction memory and the decode stage. It owns the program counter and drives the memory address. It captures each returned word with its PC into a small flushable queue and presents it to decode through a valid/ready handshake. It also handles start/stop, branch/jump redirects and, optionally, a halt opcode.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `QUEUE_DEPTH`, default 2: queue entries; power of two, 2..8.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: fetch permitted this cycle.
- `imem_addr` out 16: address to instruction memory; equals PC register.
- `imem_data` in 16: word returned combinationally for `imem_addr` in the same cycle.
- `redirect_valid` in 1: branch/jump taken; flush and reload PC.
- `redirect_pc` in 16: new PC, valid with `redirect_valid`.
- `out_valid` out 1: queue head valid.
- `out_ready` in 1: decode accepts head.
- `out_instr` out 16: head instruction word.
- `out_pc` out 16: address of head instruction.
- `queue_count` out clog2(QUEUE_DEPTH)+1: occupied entries.
- `halted` out 1: fetcher in HALT state.

## Operation
- FSM states:
  - IDLE (reset state).
  - FETCH.
  - HALT (only reachable with the macro).
- IDLE: no pushes. `enable`=1 moves to FETCH at the next edge; the first push occurs in the FETCH cycle.
- FETCH, push condition: `enable`=1 and no redirect and (count<QUEUE_DEPTH or pop this cycle). When met, push {PC, `imem_data`} at the edge and set PC to PC+1, 16-bit wrap, so 16'hFFFF goes to 16'h0000.
- FETCH, `enable`=0: no push, PC held; stays in FETCH with the queue retained.
- Pop: `out_valid` && `out_ready`. Head advances.
- `out_valid` equals count!=0.
- `out_instr` and `out_pc` hold stable while `out_valid` && !`out_ready`.
- Redirect has highest priority in every state:
  - Queue count goes to 0 and PC goes to `redirect_pc`.
  - No push or pop takes effect that cycle; a simultaneous pop is discarded.
  - From HALT, go to FETCH; from IDLE, stay IDLE; FETCH stays FETCH.
- Simultaneous push and pop with the queue full: allowed, count unchanged.
- Reset mid-operation: all state returns to reset values immediately, and the queue contents are lost.

## Timing
- Reset values:
  - `imem_addr`=RESET_PC
  - `out_valid`=0
  - `out_instr`=16'h0000
  - `out_pc`=16'h0000
  - `queue_count`=0
  - `halted`=0
  - state IDLE
- `out_instr`/`out_pc` are 0 whenever `out_valid`=0.
- Fetch latency: a word pushed at edge N is visible with `out_valid`=1 from cycle N+1.
- Redirect at edge N: `imem_addr`=`redirect_pc` during cycle N+1, and that instruction is on `out_*` from cycle N+2.
- Sustained throughput: 1 instruction/cycle with `out_ready` held at 1.
- `out_*` are driven from registers; nothing from `out_ready` reaches `imem_addr` combinationally except the push-enable.

## Configuration
- `IFETCH_HALT_DETECT_EN` defined:
  - A pushed word with `[15:12]`==4'hF still enters the queue, then the FSM goes to HALT.
  - In HALT, PC stays at the halt address, `halted`=1, and there are no further pushes.
  - The queue continues draining.
  - Only redirect or reset leave HALT.
- `IFETCH_HALT_DETECT_EN` undefined: opcode 4'hF is fetched like any other word, HALT is unreachable, and `halted` is tied to 0.

## Structure
- Package `ifetch_pkg` holds:
  - State enum {IDLE, FETCH, HALT}.
  - `IF_ADDR_W`=16 and `IF_INSTR_W`=16.
  - `HALT_OPCODE`=4'hF.
- Sub-module `ifetch_queue`: synchronous FIFO of {pc, instr} with push, pop, flush and count. Flush has priority over push/pop.
- Top: FSM, PC register and push-enable logic.

## Test plan
- Reset, `enable`=1, `out_ready`=1, memory 0..3 = 1111,2222,3333,4444 → `out_valid` from cycle 2; (`out_pc`,`out_instr`) = (0,1111),(1,2222),(2,3333),… one per cycle.
- `out_ready`=0 for 5 cycles → `queue_count` saturates at 2, `imem_addr` frozen at 2, `out_instr` holds 1111; release → 2222,3333 follow with no loss or duplication.
- `redirect_valid`=1 with `redirect_pc`=16'h0040 while the queue is full and `out_ready`=1 → count 0 the next cycle, `imem_addr`=0040, and the first output is (0040, mem[0040]).
- PC at 16'hFFFF with fetch running → next `imem_addr`=16'h0000, and `out_pc` sequence FFFF,0000.
- Macro on, mem[5]=F000 → F000 delivered, `halted`=1, `imem_addr` stays 5; redirect to 0 → `halted`=0 and fetch resumes at 0. Macro off → F000 then mem[6] delivered, `halted`=0.
- Assert `rst_n`=0 mid-stream → `out_valid`=0 and `imem_addr`=RESET_PC immediately, without waiting for a clock edge.
